// File: rtl/simd_ex_pkg.sv
// rtl/simd_ex_pkg.sv - shared op/forward/state encodings and the GF(2^8) xtime helper for the SIMD execute stage
package simd_ex_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SHL   = 4'd5,
        OP_SHR   = 4'd6,
        OP_ROTL  = 4'd7,
        OP_PASSB = 4'd8,
        OP_GFMUL = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        FW_REG   = 2'd0,
        FW_EXMEM = 2'd1,
        FW_MEMWB = 2'd2,
        FW_WB    = 2'd3
    } fw_sel_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } ex_state_t;

    // Multiply by x in GF(2^8); poly is the reduction polynomial without the x^8 term.
    function automatic logic [7:0] xtime(input logic [7:0] a, input logic [7:0] poly);
        return {a[6:0], 1'b0} ^ (a[7] ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/simd_lane_alu.sv
// rtl/simd_lane_alu.sv - one lane's single-cycle ALU plus one shift-and-add GF step (SIMD_GFMUL_EN)
module simd_lane_alu
    import simd_ex_pkg::*;
#(
    parameter int LANE_W = 8
) (
    input  logic [LANE_W-1:0] a_i,
    input  logic [LANE_W-1:0] b_i,
    input  alu_op_t           op_i,
`ifdef SIMD_GFMUL_EN
    input  logic [7:0]        poly_i,
    input  logic [7:0]        gf_acc_i,
    input  logic [7:0]        gf_a_i,
    input  logic              gf_bit_i,
    output logic [7:0]        gf_acc_o,
    output logic [7:0]        gf_a_o,
`endif
    output logic [LANE_W-1:0] result_o,
    output logic              illegal_o
);

    localparam int SH_W = $clog2(LANE_W);

    logic [SH_W-1:0] sh;
    assign sh = b_i[SH_W-1:0];

    always_comb begin
        result_o  = '0;
        illegal_o = 1'b0;
        case (op_i)
            OP_ADD:   result_o = a_i + b_i;
            OP_SUB:   result_o = a_i - b_i;
            OP_AND:   result_o = a_i & b_i;
            OP_OR:    result_o = a_i | b_i;
            OP_XOR:   result_o = a_i ^ b_i;
            OP_SHL:   result_o = a_i << sh;
            OP_SHR:   result_o = a_i >> sh;
            // A right shift by the full width yields zero, so sh==0 is a plain pass
            OP_ROTL:  result_o = (a_i << sh) | (a_i >> (LANE_W - int'(sh)));
            OP_PASSB: result_o = b_i;
`ifdef SIMD_GFMUL_EN
            OP_GFMUL: result_o = '0;
`endif
            default:  illegal_o = 1'b1;
        endcase
    end

`ifdef SIMD_GFMUL_EN
    assign gf_acc_o = gf_bit_i ? (gf_acc_i ^ gf_a_i) : gf_acc_i;
    assign gf_a_o   = xtime(gf_a_i, poly_i);
`endif

endmodule

// File: rtl/simd_ex_stage.sv
// rtl/simd_ex_stage.sv - SIMD execute stage: forwarding, lane ALUs, output register, handshake
// Optional iterative GF(2^8) multiply enabled by SIMD_GFMUL_EN.
module simd_ex_stage
    import simd_ex_pkg::*;
#(
    parameter int         LANES  = 4,
    parameter int         LANE_W = 8,
    parameter logic [7:0] POLY   = 8'h1B
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*LANE_W-1:0]  data1,
    input  logic [LANES*LANE_W-1:0]  data2,
    input  logic [LANES*LANE_W-1:0]  imm,
    input  logic [LANES*LANE_W-1:0]  fw1,
    input  logic [LANES*LANE_W-1:0]  fw2,
    input  logic [LANES*LANE_W-1:0]  fw3,
    input  logic [1:0]               sel_fw_a,
    input  logic [1:0]               sel_fw_b,
    input  logic                     alu_src,
    input  logic [3:0]               alu_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*LANE_W-1:0]  alu_result,
    output logic [LANES*LANE_W-1:0]  write_data,
    output logic                     busy,
    output logic                     illegal_op
);

    localparam int W = LANES * LANE_W;

    logic [W-1:0]     op_a, fwd_b, op_b, lane_res;
    logic [LANES-1:0] lane_ill;
    logic             accept;

    logic [W-1:0]     alu_result_q, write_data_q;
    logic             out_valid_q, illegal_q;

    always_comb begin
        op_a = data1;
        case (fw_sel_t'(sel_fw_a))
            FW_EXMEM: op_a = fw1;
            FW_MEMWB: op_a = fw2;
            FW_WB:    op_a = fw3;
            default:  op_a = data1;
        endcase
        fwd_b = data2;
        case (fw_sel_t'(sel_fw_b))
            FW_EXMEM: fwd_b = fw1;
            FW_MEMWB: fwd_b = fw2;
            FW_WB:    fwd_b = fw3;
            default:  fwd_b = data2;
        endcase
        op_b = alu_src ? imm : fwd_b;
    end

`ifdef SIMD_GFMUL_EN
    localparam int               CNT_W    = $clog2(LANE_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LANE_W - 1);

    ex_state_t        state_q;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     acc_q, ma_q, mb_q, acc_nx, ma_nx, mb_nx;
`endif

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        simd_lane_alu #(.LANE_W(LANE_W)) u_alu (
            .a_i       (op_a[l*LANE_W +: LANE_W]),
            .b_i       (op_b[l*LANE_W +: LANE_W]),
            .op_i      (alu_op_t'(alu_op)),
`ifdef SIMD_GFMUL_EN
            .poly_i    (POLY),
            .gf_acc_i  (acc_q[l*8 +: 8]),
            .gf_a_i    (ma_q[l*8 +: 8]),
            .gf_bit_i  (mb_q[l*8]),
            .gf_acc_o  (acc_nx[l*8 +: 8]),
            .gf_a_o    (ma_nx[l*8 +: 8]),
`endif
            .result_o  (lane_res[l*LANE_W +: LANE_W]),
            .illegal_o (lane_ill[l])
        );
`ifdef SIMD_GFMUL_EN
        // Multiplier bits are consumed LSB first, one per cycle
        assign mb_nx[l*8 +: 8] = {1'b0, mb_q[l*8+1 +: 7]};
`endif
    end

    assign accept = in_valid && in_ready;

`ifdef SIMD_GFMUL_EN
    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign busy     = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
            acc_q        <= '0;
            ma_q         <= '0;
            mb_q         <= '0;
            out_valid_q  <= 1'b0;
            alu_result_q <= '0;
            write_data_q <= '0;
            illegal_q    <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (accept) begin
                    write_data_q <= fwd_b;
                    if (alu_op_t'(alu_op) == OP_GFMUL) begin
                        state_q <= ST_MUL;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        ma_q    <= op_a;
                        mb_q    <= op_b;
                    end else begin
                        alu_result_q <= lane_res;
                        illegal_q    <= |lane_ill;
                        out_valid_q  <= 1'b1;
                    end
                end
                ST_MUL: begin
                    acc_q <= acc_nx;
                    ma_q  <= ma_nx;
                    mb_q  <= mb_nx;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        alu_result_q <= acc_nx;
                        illegal_q    <= 1'b0;
                        out_valid_q  <= 1'b1;
                        state_q      <= ST_IDLE;
                        busy_q       <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
`else
    logic unused_poly;
    assign unused_poly = ^POLY;
    assign in_ready    = !out_valid_q || out_ready;
    assign busy        = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            alu_result_q <= '0;
            write_data_q <= '0;
            illegal_q    <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) out_valid_q <= 1'b0;
            if (accept) begin
                write_data_q <= fwd_b;
                alu_result_q <= lane_res;
                illegal_q    <= |lane_ill;
                out_valid_q  <= 1'b1;
            end
        end
    end
`endif

    assign out_valid  = out_valid_q;
    assign alu_result = alu_result_q;
    assign write_data = write_data_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_simd_ex_stage.sv
// tb/tb_simd_ex_stage.sv - self-checking bench: vector table, handshake/GF corner sequences, random vs reference model
module tb_simd_ex_stage;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, in_valid, out_ready, alu_src;
    logic [1:0]   sel_fw_a, sel_fw_b;
    logic [3:0]   alu_op;
    logic [W-1:0] data1, data2, imm, fw1, fw2, fw3;
    logic         in_ready, out_valid, busy, illegal_op;
    logic [W-1:0] alu_result, write_data;

    int total = 0;
    int bad   = 0;

    simd_ex_stage #(.LANES(4), .LANE_W(8), .POLY(8'h1B)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data1(data1), .data2(data2), .imm(imm), .fw1(fw1), .fw2(fw2), .fw3(fw3),
        .sel_fw_a(sel_fw_a), .sel_fw_b(sel_fw_b), .alu_src(alu_src), .alu_op(alu_op),
        .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
        .write_data(write_data), .busy(busy), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] wd;
        logic        ill;
    } exp_t;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [1:0]  sa, sb;
        logic        src;
        logic [31:0] d1, d2, im, f1, f2, f3;
        logic [31:0] res, wd;
        logic        ill;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        alu_op = v.op; sel_fw_a = v.sa; sel_fw_b = v.sb; alu_src = v.src;
        data1 = v.d1; data2 = v.d2; imm = v.im; fw1 = v.f1; fw2 = v.f2; fw3 = v.f3;
    endtask

    function automatic logic [7:0] ref_gfmul(input logic [7:0] a, input logic [7:0] b);
        int p = 0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (int'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (32'h11B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] r,
                                         input logic [31:0] f1, input logic [31:0] f2,
                                         input logic [31:0] f3);
        return (s == 2'd0) ? r : (s == 2'd1) ? f1 : (s == 2'd2) ? f2 : f3;
    endfunction

    function automatic exp_t model(input vec_t v);
        exp_t        e;
        logic [31:0] a, fb, b;
        int          x, y, sh, r;
        a  = pick(v.sa, v.d1, v.f1, v.f2, v.f3);
        fb = pick(v.sb, v.d2, v.f1, v.f2, v.f3);
        b  = v.src ? v.im : fb;
        e.wd  = fb;
        e.ill = 1'b0;
        e.res = '0;
        for (int l = 0; l < 4; l++) begin
            x = int'(a[l*8 +: 8]);
            y = int'(b[l*8 +: 8]);
            sh = y % 8;
            r = 0;
            case (int'(v.op))
                0: r = (x + y) % 256;
                1: r = (x - y + 256) % 256;
                2: r = x & y;
                3: r = x | y;
                4: r = x ^ y;
                5: r = (x << sh) % 256;
                6: r = x >> sh;
                7: r = ((x << sh) | (x >> (8 - sh))) % 256;
                8: r = y;
`ifdef SIMD_GFMUL_EN
                9: r = int'(ref_gfmul(x[7:0], y[7:0]));
`endif
                default: e.ill = 1'b1;
            endcase
            e.res[l*8 +: 8] = r[7:0];
        end
        if (e.ill) e.res = '0;
        return e;
    endfunction

    vec_t tbl[12];
    vec_t v;
    exp_t q[$];
    exp_t ex;
    int   lat;
    logic stall_ok;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; alu_src = 1'b0;
        sel_fw_a = '0; sel_fw_b = '0; alu_op = '0;
        data1 = '0; data2 = '0; imm = '0; fw1 = '0; fw2 = '0; fw3 = '0;

        tbl[0]  = '{"add",   4'd0,  2'd0, 2'd0, 1'b0, 32'h107F01FF, 32'hF0010101, 32'h0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h00800200, 32'hF0010101, 1'b0};
        tbl[1]  = '{"or_fw2",4'd3,  2'd2, 2'd0, 1'b1, 32'h0BADF00D, 32'h12345678, 32'h0, 32'h11111111, 32'hDEADBEEF, 32'h33333333, 32'hDEADBEEF, 32'h12345678, 1'b0};
        tbl[2]  = '{"sub",   4'd1,  2'd0, 2'd0, 1'b0, 32'h00000010, 32'h01010101, 32'h0, 32'h11111111, 32'h22222222, 32'h33333333, 32'hFFFFFF0F, 32'h01010101, 1'b0};
        tbl[3]  = '{"and",   4'd2,  2'd1, 2'd3, 1'b0, 32'h0, 32'h0, 32'h0, 32'hF0F0FF00, 32'h22222222, 32'hFF0F0FF0, 32'hF0000F00, 32'hFF0F0FF0, 1'b0};
        tbl[4]  = '{"xor",   4'd4,  2'd0, 2'd0, 1'b1, 32'hAAAA5555, 32'hCAFEBABE, 32'hFF00FF00, 32'h11111111, 32'h22222222, 32'h33333333, 32'h55AAAA55, 32'hCAFEBABE, 1'b0};
        tbl[5]  = '{"shl",   4'd5,  2'd0, 2'd0, 1'b1, 32'h01FF8081, 32'h13572468, 32'h07030101, 32'h11111111, 32'h22222222, 32'h33333333, 32'h80F80002, 32'h13572468, 1'b0};
        tbl[6]  = '{"shr",   4'd6,  2'd0, 2'd0, 1'b0, 32'h80FF8081, 32'h0F030107, 32'h0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h011F4001, 32'h0F030107, 1'b0};
        tbl[7]  = '{"rotl",  4'd7,  2'd0, 2'd0, 1'b0, 32'h1281F081, 32'h08030400, 32'h0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h120C0F81, 32'h08030400, 1'b0};
        tbl[8]  = '{"passb", 4'd8,  2'd3, 2'd2, 1'b0, 32'h0, 32'h0, 32'h0, 32'h11111111, 32'h5A5AA5A5, 32'h33333333, 32'h5A5AA5A5, 32'h5A5AA5A5, 1'b0};
        tbl[9]  = '{"op15",  4'd15, 2'd0, 2'd0, 1'b0, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h00000000, 32'h9ABCDEF0, 1'b1};
        tbl[10] = '{"op10",  4'd10, 2'd0, 2'd0, 1'b0, 32'hFFFFFFFF, 32'h01020304, 32'h0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h00000000, 32'h01020304, 1'b1};
`ifdef SIMD_GFMUL_EN
        tbl[11] = '{"op12",  4'd12, 2'd0, 2'd0, 1'b0, 32'h57575757, 32'h83838383, 32'h0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h00000000, 32'h83838383, 1'b1};
`else
        tbl[11] = '{"op9",   4'd9,  2'd0, 2'd0, 1'b0, 32'h57575757, 32'h83838383, 32'h0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h00000000, 32'h83838383, 1'b1};
`endif

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid",  out_valid,  0);
        check("rst_alu_result", alu_result, 0);
        check("rst_write_data", write_data, 0);
        check("rst_busy",       busy,       0);
        check("rst_illegal",    illegal_op, 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready",   in_ready,   1);

        for (int i = 0; i < 12; i++) begin
            apply(tbl[i]);
            in_valid = 1'b1;
            #1;
            check({tbl[i].name, "_in_ready"}, in_ready, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            check({tbl[i].name, "_valid"},   out_valid,  1);
            check({tbl[i].name, "_result"},  alu_result, tbl[i].res);
            check({tbl[i].name, "_wdata"},   write_data, tbl[i].wd);
            check({tbl[i].name, "_illegal"}, illegal_op, tbl[i].ill);
        end

        // Stall: result must hold and no new accept until drained
        @(posedge clk); #1;
        out_ready = 1'b0;
        apply(tbl[0]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("hold_first_valid", out_valid, 1);
        apply(tbl[2]);
        for (int i = 0; i < 3; i++) begin
            check("hold_in_ready", in_ready,   0);
            check("hold_result",   alu_result, 32'h00800200);
            check("hold_valid",    out_valid,  1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        check("drain_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("drain_accept_valid",  out_valid,  1);
        check("drain_accept_result", alu_result, 32'hFFFFFF0F);
        @(posedge clk); #1;
        check("drain_empty_valid", out_valid, 0);
        check("drain_busy",        busy,      0);

`ifdef SIMD_GFMUL_EN
        v = tbl[0];
        v.op = 4'd9; v.d1 = 32'h57575757; v.d2 = 32'h83838383;
        apply(v);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        stall_ok = 1'b1;
        while (!out_valid && lat < 20) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) stall_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check("gf_latency",    lat,        8);
        check("gf_busy_stall", stall_ok,   1);
        check("gf_result",     alu_result, 32'hC1C1C1C1);
        check("gf_wdata",      write_data, 32'h83838383);
        check("gf_illegal",    illegal_op, 0);
        check("gf_busy_done",  busy,       0);

        @(posedge clk); #1;
        apply(v);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("gfrst_valid",    out_valid, 0);
        check("gfrst_busy",     busy,      0);
        check("gfrst_in_ready", in_ready,  1);
        rst = 1'b0;
        apply(tbl[0]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("gfrst_add_valid",  out_valid,  1);
        check("gfrst_add_result", alu_result, 32'h00800200);
`endif

        // Random traffic with random back-pressure against the reference model
        for (int it = 0; it < 400; it++) begin
            v = tbl[0];
            v.op  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
            v.sa  = 2'($urandom_range(0, 3));
            v.sb  = 2'($urandom_range(0, 3));
            v.src = 1'($urandom_range(0, 1));
            v.d1 = $urandom; v.d2 = $urandom; v.im = $urandom;
            v.f1 = $urandom; v.f2 = $urandom; v.f3 = $urandom;
            apply(v);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rnd_queue_nonempty", 32'(q.size()), 32'd1);
                end else begin
                    ex = q.pop_front();
                    check("rnd_result",  alu_result, ex.res);
                    check("rnd_wdata",   write_data, ex.wd);
                    check("rnd_illegal", illegal_op, ex.ill);
                end
            end
            if (in_valid && in_ready) q.push_back(model(v));
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("rnd_drain_nonempty", 32'(q.size()), 32'd1);
                end else begin
                    ex = q.pop_front();
                    check("rnd_drain_result",  alu_result, ex.res);
                    check("rnd_drain_wdata",   write_data, ex.wd);
                    check("rnd_drain_illegal", illegal_op, ex.ill);
                end
            end
            @(posedge clk); #1;
        end
        check("rnd_queue_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
